shift_seq_unit: RTL and testbench
=================================

SHIFT_SEQ_UNIT -- requirements
Module: shift_seq_unit

Interface
REQ-001 Parameter: WIDTH, 32, datapath width; amount width AW = log2(WIDTH) = 5 at default.
REQ-002 clk_i  input  1  clock; all state changes on rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 start_i  input  1  request; sampled only in IDLE.
REQ-005 src1_i  input  WIDTH  variable-amount source; bits [AW-1:0] used by *V ops.
REQ-006 src2_i  input  WIDTH  operand to be shifted.
REQ-007 ctrl_i  input  4  operation select.
REQ-008 shamt_i  input  AW  immediate shift amount.
REQ-009 busy_o  output  1  high while an operation is in progress.
REQ-010 done_o  output  1  one-cycle completion pulse.
REQ-011 illegal_o  output  1  set with done_o when ctrl_i was unsupported.
REQ-012 result_o  output  WIDTH  shifted value; held until next accepted start.

Function
REQ-013 ctrl encoding: 0000 SLL (shamt_i), 0001 SRL (shamt_i), 0010 SRA (shamt_i), 0011 SLLV (src1_i[AW-1:0]), 0100 SRLV (src1_i[AW-1:0]), 0101 SRAV (src1_i[AW-1:0]); all other codes illegal.
REQ-014 States: IDLE, SHIFT, DONE; reset state IDLE.
REQ-015 IDLE, start_i=1: capture src2_i into data reg, selected amount N into counter, direction/arith mode into mode reg; go SHIFT; busy_o=1 next cycle.
REQ-016 Illegal ctrl at start: N forced 0, data reg = src2_i, illegal flag latched.
REQ-017 IDLE, start_i=0: remain IDLE, outputs held.
REQ-018 SHIFT, counter != 0: shift data reg by exactly 1 bit (left: LSB 0; logical right: MSB 0; arithmetic right: MSB replicated), decrement counter, stay SHIFT.
REQ-019 SHIFT, counter == 0: go DONE; result_o <= data reg; illegal_o <= latched flag.
REQ-020 DONE: done_o=1 for exactly this one cycle, busy_o=0; unconditionally go IDLE next edge.
REQ-021 Latency: done_o asserted N+2 cycles after the cycle in which start_i was sampled high; N=0 gives 2.
REQ-022 start_i in SHIFT or DONE: ignored, no queuing; operand inputs ignored outside the accepting IDLE cycle.
REQ-023 Back-to-back: start_i may be accepted in the IDLE cycle immediately following DONE.
REQ-024 N = WIDTH-1 (31) is the maximum; no shift amount is ever reduced modulo or saturated beyond AW bits.
REQ-025 result_o, illegal_o change only on the SHIFT->DONE transition or reset; illegal_o clears on the next legal completion.
REQ-026 busy_o high exactly in SHIFT state; done_o and busy_o never high simultaneously.

Reset
REQ-027 rst_i=1 at a rising edge: state IDLE, busy_o=0, done_o=0, illegal_o=0, result_o=0, counter and data reg 0.
REQ-028 Reset has priority over start_i and over any in-flight operation; an aborted operation never produces done_o.
REQ-029 First start_i accepted in the first cycle with rst_i=0.

Verification
REQ-030 SLL: src2=0x00000003, shamt=4, ctrl=0000, start -> done_o at 6 cycles, result_o=0x00000030, illegal_o=0.
REQ-031 SRA vs SRL: src2=0x80000000, shamt=31 -> ctrl 0010 gives 0xFFFFFFFF, ctrl 0001 gives 0x00000001, each done at 33 cycles.
REQ-032 SRLV: src1=0x000000E4 (amount 4), shamt=0, src2=0x0000F000 -> result_o=0x00000F00; zero amount SLLV with src1=0x20 -> result_o=src2, done at 2 cycles.
REQ-033 Illegal ctrl 1111, src2=0x12345678 -> done at 2 cycles, result_o=0x12345678, illegal_o=1; following legal op clears illegal_o.
REQ-034 start_i held high through SHIFT with changing operands -> only first operands used; exactly one done_o; new op accepted in cycle after done_o.
REQ-035 rst_i asserted mid-SHIFT (SLL by 20) -> next cycle all outputs 0, no done_o; fresh SLL by 1 of 0x1 after reset -> 0x2.

Source files
------------

// File: rtl/shift_seq_unit.sv
// Multi-cycle barrel-free shifter: moves the operand one bit per cycle
// under a down-counter, then presents the result with a one-cycle done pulse.
module shift_seq_unit #(
    parameter int WIDTH = 32,
    localparam int AW = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    input  logic [AW-1:0]    shamt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             illegal_o,
    output logic [WIDTH-1:0] result_o
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    typedef enum logic [1:0] {M_LEFT, M_LOGIC, M_ARITH} mode_t;

    localparam logic [AW-1:0] CNT_ONE = AW'(1);

    state_t           state_reg, state_next;
    mode_t            mode_reg, mode_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic [AW-1:0]    cnt_reg, cnt_next;
    logic             ill_flag_reg, ill_flag_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             illegal_reg, illegal_next;

    logic             dec_legal;
    mode_t            dec_mode;
    logic [AW-1:0]    dec_amt;

    logic [WIDTH-1:0] shl_one, shr_one, shift_one;

    // Single-bit neighbours of the data register; the top bit of a right
    // shift is the old MSB only in arithmetic mode.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (gi == 0) begin : g_lsb
            assign shl_one[gi] = 1'b0;
        end else begin : g_lmid
            assign shl_one[gi] = data_reg[gi-1];
        end
        if (gi == WIDTH-1) begin : g_msb
            assign shr_one[gi] = (mode_reg == M_ARITH) & data_reg[gi];
        end else begin : g_rmid
            assign shr_one[gi] = data_reg[gi+1];
        end
    end

    assign shift_one = (mode_reg == M_LEFT) ? shl_one : shr_one;

    always_comb begin
        dec_legal = 1'b1;
        dec_mode  = M_LEFT;
        dec_amt   = shamt_i;
        case (ctrl_i)
            4'b0000: dec_mode = M_LEFT;
            4'b0001: dec_mode = M_LOGIC;
            4'b0010: dec_mode = M_ARITH;
            4'b0011: begin dec_mode = M_LEFT;  dec_amt = src1_i[AW-1:0]; end
            4'b0100: begin dec_mode = M_LOGIC; dec_amt = src1_i[AW-1:0]; end
            4'b0101: begin dec_mode = M_ARITH; dec_amt = src1_i[AW-1:0]; end
            default: begin dec_legal = 1'b0; dec_amt = '0; end
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        mode_next     = mode_reg;
        data_next     = data_reg;
        cnt_next      = cnt_reg;
        ill_flag_next = ill_flag_reg;
        result_next   = result_reg;
        illegal_next  = illegal_reg;
        case (state_reg)
            S_IDLE: begin
                if (start_i) begin
                    data_next     = src2_i;
                    cnt_next      = dec_amt;
                    mode_next     = dec_mode;
                    ill_flag_next = ~dec_legal;
                    state_next    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_reg != '0) begin
                    data_next = shift_one;
                    cnt_next  = cnt_reg - CNT_ONE;
                end else begin
                    result_next  = data_reg;
                    illegal_next = ill_flag_reg;
                    state_next   = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= S_IDLE;
            mode_reg     <= M_LEFT;
            data_reg     <= '0;
            cnt_reg      <= '0;
            ill_flag_reg <= 1'b0;
            result_reg   <= '0;
            illegal_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            mode_reg     <= mode_next;
            data_reg     <= data_next;
            cnt_reg      <= cnt_next;
            ill_flag_reg <= ill_flag_next;
            result_reg   <= result_next;
            illegal_reg  <= illegal_next;
        end
    end

    assign busy_o    = (state_reg == S_SHIFT);
    assign done_o    = (state_reg == S_DONE);
    assign result_o  = result_reg;
    assign illegal_o = illegal_reg;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Self-checking bench for shift_seq_unit: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_shift_seq_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [3:0]  ctrl_i;
    logic [4:0]  shamt_i;
    logic        busy_o;
    logic        done_o;
    logic        illegal_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] prev_result;
    logic        prev_illegal;

    always #5 clk_i = ~clk_i;

    shift_seq_unit #(.WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .src1_i(src1_i), .src2_i(src2_i), .ctrl_i(ctrl_i), .shamt_i(shamt_i),
        .busy_o(busy_o), .done_o(done_o), .illegal_o(illegal_o), .result_o(result_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: whole-word shift by the selected amount.
    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] s1,
                                          input logic [31:0] s2, input logic [4:0] sh,
                                          output bit ill, output int n);
        ill = 1'b0;
        n   = 0;
        case (c)
            4'd0: begin n = int'(sh);     return s2 << n; end
            4'd1: begin n = int'(sh);     return s2 >> n; end
            4'd2: begin n = int'(sh);     return 32'($signed(s2) >>> n); end
            4'd3: begin n = int'(s1[4:0]); return s2 << n; end
            4'd4: begin n = int'(s1[4:0]); return s2 >> n; end
            4'd5: begin n = int'(s1[4:0]); return 32'($signed(s2) >>> n); end
            default: begin ill = 1'b1; return s2; end
        endcase
    endfunction

    // Called #1 after a rising edge with the DUT in IDLE; returns #1 after
    // the edge that brings it back to IDLE.
    task automatic do_op(input logic [3:0] c, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [4:0] sh, input bit hold);
        logic [31:0] er;
        bit ei;
        int n;
        int lat;
        er = model(c, s1, s2, sh, ei, n);
        start_i = 1'b1; ctrl_i = c; src1_i = s1; src2_i = s2; shamt_i = sh;
        @(posedge clk_i); #1;
        lat = 1;
        check("busy_start", 32'(busy_o), 32'd1);
        if (!hold) start_i = 1'b0;
        while (!done_o && lat < 80) begin
            check("hold_result", result_o, prev_result);
            check("hold_illegal", 32'(illegal_o), 32'(prev_illegal));
            check("busy_shift", 32'(busy_o), 32'd1);
            if (hold) begin
                src1_i = $urandom; src2_i = $urandom;
                ctrl_i = 4'($urandom); shamt_i = 5'($urandom);
            end
            @(posedge clk_i); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(n + 2));
        check("result", result_o, er);
        check("illegal", 32'(illegal_o), 32'(ei));
        check("busy_done", 32'(busy_o), 32'd0);
        prev_result  = er;
        prev_illegal = ei;
        @(posedge clk_i); #1;
        check("done_pulse", 32'(done_o), 32'd0);
        check("busy_idle", 32'(busy_o), 32'd0);
        start_i = 1'b0;
        $display("op ctrl=%h src1=%h src2=%h shamt=%0d hold=%0d -> result=%h illegal=%0d lat=%0d",
                 c, s1, s2, sh, hold, result_o, illegal_o, lat);
    endtask

    initial begin
        bit saw_done;
        logic [3:0] c;
        rst_i = 1'b1; start_i = 1'b0; src1_i = '0; src2_i = '0; ctrl_i = '0; shamt_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_result", result_o, 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_illegal", 32'(illegal_o), 32'd0);
        rst_i = 1'b0;
        prev_result = '0; prev_illegal = 1'b0;

        do_op(4'b0000, 32'h0, 32'h0000_0003, 5'd4, 1'b0);
        check("sll_const", result_o, 32'h0000_0030);
        do_op(4'b0010, 32'h0, 32'h8000_0000, 5'd31, 1'b0);
        check("sra_const", result_o, 32'hFFFF_FFFF);
        do_op(4'b0001, 32'h0, 32'h8000_0000, 5'd31, 1'b0);
        check("srl_const", result_o, 32'h0000_0001);
        do_op(4'b0100, 32'h0000_00E4, 32'h0000_F000, 5'd0, 1'b0);
        check("srlv_const", result_o, 32'h0000_0F00);
        do_op(4'b0011, 32'h0000_0020, 32'hCAFE_BABE, 5'd7, 1'b0);
        check("sllv_zero", result_o, 32'hCAFE_BABE);
        do_op(4'b1111, 32'h0, 32'h1234_5678, 5'd9, 1'b0);
        check("illegal_res", result_o, 32'h1234_5678);
        check("illegal_set", 32'(illegal_o), 32'd1);
        do_op(4'b0000, 32'h0, 32'h0000_0001, 5'd1, 1'b0);
        check("illegal_clr", 32'(illegal_o), 32'd0);
        do_op(4'b0000, 32'h0, 32'h0000_0001, 5'd3, 1'b1);
        check("hold_const", result_o, 32'h0000_0008);

        for (int i = 0; i < 40; i++) begin
            c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
            do_op(c, $urandom, $urandom, 5'($urandom), bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk_i); #1;
            end
        end

        // Abort an SLL by 20 part-way through.
        start_i = 1'b1; ctrl_i = 4'b0000; src2_i = 32'h0001_2345; shamt_i = 5'd20;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        check("abort_busy_pre", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        check("abort_result", result_o, 32'd0);
        check("abort_illegal", 32'(illegal_o), 32'd0);
        rst_i = 1'b0;
        prev_result = '0; prev_illegal = 1'b0;
        saw_done = 1'b0;
        repeat (25) begin
            @(posedge clk_i); #1;
            if (done_o) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        do_op(4'b0000, 32'h0, 32'h0000_0001, 5'd1, 1'b0);
        check("post_reset_sll", result_o, 32'h0000_0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
